// File: rtl/clock24_timekeeper.sv
`default_nettype none
// ============================================================================
//  Module      : clock24_timekeeper
//  Description : 24-hour BCD HH:MM:SS timekeeper with 1 Hz prescaler, key
//                driven set mode and blinking digit enables for the edited pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock24_timekeeper #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY_MODE,
    input  logic       KEY_INC,
    output logic [3:0] HOUR_T,
    output logic [3:0] HOUR_U,
    output logic [3:0] MIN_T,
    output logic [3:0] MIN_U,
    output logic [3:0] SEC_T,
    output logic [3:0] SEC_U,
    output logic [5:0] EN,
    output logic [1:0] MODE,
    output logic       TICK_1HZ
);

    localparam int PRE_W   = (CLK_HZ > 1)    ? $clog2(CLK_HZ)    : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(CLK_HZ - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [5:0] EN_ALL      = 6'b111111;
    localparam logic [5:0] EN_HOUR_OFF = 6'b001111;
    localparam logic [5:0] EN_MIN_OFF  = 6'b110011;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    mode_t              mode_q;
    logic [PRE_W-1:0]   prescaler;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    logic sec_carry;
    logic min_carry;

    assign sec_carry = (SEC_T == 4'd5) && (SEC_U == 4'd9);
    assign min_carry = (MIN_T == 4'd5) && (MIN_U == 4'd9);
    assign MODE      = mode_q;

    // Two-digit BCD 00..59 increment with wrap; used for seconds and minutes.
    function automatic logic [7:0] sexa_next(input logic [3:0] t, input logic [3:0] u);
        if (u == 4'd9) begin
            if (t == 4'd5) return 8'h00;
            else           return {t + 4'd1, 4'd0};
        end
        return {t, u + 4'd1};
    endfunction

    function automatic logic [7:0] hour_next(input logic [3:0] t, input logic [3:0] u);
        if (t == 4'd2 && u == 4'd3) return 8'h00;
        if (u == 4'd9)              return {t + 4'd1, 4'd0};
        return {t, u + 4'd1};
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q      <= RUN;
            prescaler   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            HOUR_T      <= 4'd0;
            HOUR_U      <= 4'd0;
            MIN_T       <= 4'd0;
            MIN_U       <= 4'd0;
            SEC_T       <= 4'd0;
            SEC_U       <= 4'd0;
            EN          <= EN_ALL;
            TICK_1HZ    <= 1'b0;
        end else begin
            TICK_1HZ <= 1'b0;
            case (mode_q)
                RUN: begin
                    blink_cnt   <= '0;
                    blink_phase <= 1'b0;
                    EN          <= EN_ALL;
                    if (prescaler == PRE_LAST) begin
                        prescaler        <= '0;
                        TICK_1HZ         <= 1'b1;
                        {SEC_T, SEC_U}   <= sexa_next(SEC_T, SEC_U);
                        if (sec_carry)
                            {MIN_T, MIN_U} <= sexa_next(MIN_T, MIN_U);
                        if (sec_carry && min_carry)
                            {HOUR_T, HOUR_U} <= hour_next(HOUR_T, HOUR_U);
                    end else begin
                        prescaler <= prescaler + PRE_W'(1);
                    end
                    // A coincident tick is kept; the set mode holds the prescaler at 0.
                    if (KEY_MODE) begin
                        mode_q    <= SET_HOUR;
                        prescaler <= '0;
                    end
                end
                SET_HOUR, SET_MIN: begin
                    prescaler <= '0;
                    if (KEY_MODE) begin
                        blink_cnt   <= '0;
                        blink_phase <= 1'b0;
                        EN          <= EN_ALL;
                        if (mode_q == SET_HOUR) begin
                            mode_q <= SET_MIN;
                        end else begin
                            mode_q <= RUN;
                            SEC_T  <= 4'd0;
                            SEC_U  <= 4'd0;
                        end
                    end else if (KEY_INC) begin
                        blink_cnt   <= '0;
                        blink_phase <= 1'b0;
                        EN          <= EN_ALL;
                        if (mode_q == SET_HOUR)
                            {HOUR_T, HOUR_U} <= hour_next(HOUR_T, HOUR_U);
                        else
                            {MIN_T, MIN_U} <= sexa_next(MIN_T, MIN_U);
                    end else if (blink_cnt == BLINK_LAST) begin
                        blink_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                        if (blink_phase)
                            EN <= EN_ALL;
                        else
                            EN <= (mode_q == SET_HOUR) ? EN_HOUR_OFF : EN_MIN_OFF;
                    end else begin
                        blink_cnt <= blink_cnt + BLINK_W'(1);
                    end
                end
                default: begin
                    mode_q      <= RUN;
                    prescaler   <= '0;
                    blink_cnt   <= '0;
                    blink_phase <= 1'b0;
                    EN          <= EN_ALL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock24_timekeeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock24_timekeeper
//  Description : Self-checking bench: vector table, directed corner sequences
//                and random keys against a seconds-of-day reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock24_timekeeper;

    localparam int CLK_HZ    = 4;
    localparam int BLINK_DIV = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic [3:0] hour_t, hour_u, min_t, min_u, sec_t, sec_u;
    logic [5:0] en;
    logic [1:0] mode;
    logic       tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time as seconds of day plus abstract counters.
    int m_tod, m_mode, m_pre, m_bc, m_ph, m_tick;

    clock24_timekeeper #(.CLK_HZ(CLK_HZ), .BLINK_DIV(BLINK_DIV)) dut (
        .CLK      (clk),
        .RST      (rst),
        .KEY_MODE (key_mode),
        .KEY_INC  (key_inc),
        .HOUR_T   (hour_t),
        .HOUR_U   (hour_u),
        .MIN_T    (min_t),
        .MIN_U    (min_u),
        .SEC_T    (sec_t),
        .SEC_U    (sec_u),
        .EN       (en),
        .MODE     (mode),
        .TICK_1HZ (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic km, input logic ki);
        int m;
        if (r) begin
            m_tod = 0; m_mode = 0; m_pre = 0; m_bc = 0; m_ph = 0; m_tick = 0;
        end else begin
            m_tick = 0;
            if (m_mode == 0) begin
                if (m_pre == CLK_HZ - 1) begin
                    m_pre = 0; m_tick = 1; m_tod = (m_tod + 1) % 86400;
                end else begin
                    m_pre++;
                end
                if (km) begin m_mode = 1; m_pre = 0; end
                m_bc = 0; m_ph = 0;
            end else begin
                m_pre = 0;
                if (km) begin
                    m_mode = (m_mode == 1) ? 2 : 0;
                    m_bc = 0; m_ph = 0;
                    if (m_mode == 0) m_tod = m_tod - (m_tod % 60);
                end else if (ki) begin
                    if (m_mode == 1) begin
                        m_tod = (m_tod + 3600) % 86400;
                    end else begin
                        m = (m_tod / 60) % 60;
                        m_tod = m_tod + (((m + 1) % 60) - m) * 60;
                    end
                    m_bc = 0; m_ph = 0;
                end else if (m_bc == BLINK_DIV - 1) begin
                    m_bc = 0; m_ph = 1 - m_ph;
                end else begin
                    m_bc++;
                end
            end
        end
    endtask

    function automatic logic [5:0] model_en();
        if (m_ph == 0 || m_mode == 0) return 6'b111111;
        return (m_mode == 1) ? 6'b001111 : 6'b110011;
    endfunction

    task automatic check_model();
        int hh, mm, ss;
        hh = m_tod / 3600;
        mm = (m_tod / 60) % 60;
        ss = m_tod % 60;
        check("model hour_t", 32'(hour_t), hh / 10);
        check("model hour_u", 32'(hour_u), hh % 10);
        check("model min_t",  32'(min_t),  mm / 10);
        check("model min_u",  32'(min_u),  mm % 10);
        check("model sec_t",  32'(sec_t),  ss / 10);
        check("model sec_u",  32'(sec_u),  ss % 10);
        check("model en",     32'(en),     32'(model_en()));
        check("model mode",   32'(mode),   m_mode);
        check("model tick",   32'(tick),   m_tick);
    endtask

    task automatic cycle(input logic r, input logic km, input logic ki);
        rst = r; key_mode = km; key_inc = ki;
        @(posedge clk);
        model_step(r, km, ki);
        #1;
        check_model();
        rst = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
    endtask

    task automatic check_time(input string name, input int hh, input int mm, input int ss);
        check({name, " hours"},   32'(hour_t) * 10 + 32'(hour_u), hh);
        check({name, " minutes"}, 32'(min_t) * 10 + 32'(min_u), mm);
        check({name, " seconds"}, 32'(sec_t) * 10 + 32'(sec_u), ss);
    endtask

    task automatic press_inc(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b1);
    endtask

    // Runs until n ticks were seen or the cycle budget expires.
    task automatic run_ticks(input int n, output int got);
        got = 0;
        for (int k = 0; k < n * CLK_HZ + 8 && got < n; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (tick === 1'b1) got++;
        end
    endtask

    typedef struct {
        logic       r, km, ki;
        int         hh, mm, ss;
        logic [5:0] en;
        logic [1:0] md;
        logic       tk;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int got;
        logic [5:0] exp_en;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 6'b111111, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 6'b111111, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 6'b111111, 2'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 6'b111111, 2'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 6'b111111, 2'd0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 6'b111111, 2'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 0, 0, 1, 6'b111111, 2'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 6'b111111, 2'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 6'b001111, 2'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1, 0, 1, 6'b111111, 2'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1, 0, 1, 6'b111111, 2'd2, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1, 1, 1, 6'b111111, 2'd2, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1, 1, 0, 6'b111111, 2'd0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1, 1, 0, 6'b111111, 2'd0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1, 1, 0, 6'b111111, 2'd0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1, 1, 0, 6'b111111, 2'd0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1, 1, 1, 6'b111111, 2'd0, 1'b1};

        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].r, vecs[i].km, vecs[i].ki);
            check_time($sformatf("vec%0d", i), vecs[i].hh, vecs[i].mm, vecs[i].ss);
            check($sformatf("vec%0d en", i),   32'(en),   32'(vecs[i].en));
            check($sformatf("vec%0d mode", i), 32'(mode), 32'(vecs[i].md));
            check($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].tk));
        end

        // Midnight rollover from 23:59 set by keys.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        press_inc(23);
        cycle(1'b0, 1'b1, 1'b0);
        press_inc(59);
        cycle(1'b0, 1'b1, 1'b0);
        check_time("set 23:59", 23, 59, 0);
        run_ticks(59, got);
        check("rollover tick59 count", got, 59);
        check_time("before midnight", 23, 59, 59);
        run_ticks(1, got);
        check("rollover tick60 count", got, 1);
        check_time("midnight", 0, 0, 0);

        // Hour wrap 23->00 and minute wrap without carry into hours.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        press_inc(25);
        check_time("25 hour presses", 1, 0, 0);
        cycle(1'b0, 1'b1, 1'b0);
        press_inc(58);
        check_time("minutes 58", 1, 58, 0);
        press_inc(3);
        check_time("minute wrap", 1, 1, 0);

        // Blink of the hour pair in SET_HOUR.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            exp_en = (((k >> 1) & 1) == 1) ? 6'b001111 : 6'b111111;
            check($sformatf("blink en k=%0d", k), 32'(en), 32'(exp_en));
            check($sformatf("blink tick k=%0d", k), 32'(tick), 0);
        end

        // MODE with INC together drops the increment.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        press_inc(2);
        cycle(1'b0, 1'b1, 1'b1);
        check("mode+inc mode", 32'(mode), 2);
        check_time("mode+inc", 2, 0, 0);

        // Leaving SET_MIN clears seconds and restarts the prescaler.
        cycle(1'b1, 1'b0, 1'b0);
        run_ticks(37, got);
        check("sec37 tick count", got, 37);
        check_time("at 37 s", 0, 0, 37);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check_time("back to run", 0, 0, 0);
        for (int k = 1; k <= CLK_HZ; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            check($sformatf("first tick k=%0d", k), 32'(tick), (k == CLK_HZ) ? 1 : 0);
        end
        check_time("first second", 0, 0, 1);

        // Reset in the middle of SET_MIN.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        press_inc(12);
        cycle(1'b0, 1'b1, 1'b0);
        press_inc(34);
        check_time("set 12:34", 12, 34, 0);
        check("set 12:34 mode", 32'(mode), 2);
        cycle(1'b1, 1'b0, 1'b0);
        check_time("mid reset", 0, 0, 0);
        check("mid reset mode", 32'(mode), 0);
        check("mid reset en", 32'(en), 32'h3f);
        for (int k = 1; k <= CLK_HZ; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            check($sformatf("post reset tick k=%0d", k), 32'(tick), (k == CLK_HZ) ? 1 : 0);
        end

        // Random keys and occasional reset, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 299) == 0),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
